// File: rtl/ghr_pkg.sv
// Shared constants for the global history register: reset default,
// legacy 2-bit state names and default parameter values.
package ghr_pkg;

  localparam logic [1:0] GHR_RESET_DEFAULT = 2'b01;

  // Names of the legacy 2-bit history values (oldest bit on the left).
  typedef enum logic [1:0] {
    UU = 2'b00,
    UT = 2'b01,
    TU = 2'b10,
    TT = 2'b11
  } ghr2_state_e;

  localparam int DEF_HIST_W       = 2;
  localparam int DEF_MAX_INFLIGHT = 4;

endpackage

// File: rtl/ghr_spec_if.sv
// Bus between the fetch/execute pipeline and the global history register.
interface ghr_spec_if #(
  parameter int HIST_W       = 2,
  parameter int MAX_INFLIGHT = 4
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  // Prediction handshake: PredValidF is the valid, ~InFlightFull is the ready;
  // a prediction is taken only in a cycle where both hold, otherwise it is
  // dropped (fetch is expected to stall while InFlightFull is high).
  logic              stallE;
  logic              BranchOpEb0;
  logic              PCSrcResE;
  logic              MispredictE;
  logic              PredValidF;
  logic              PredTakenF;
  logic [HIST_W-1:0] GHRSpec;
  logic [HIST_W-1:0] GHRArch;
  logic [CNT_W-1:0]  InFlight;
  logic              InFlightFull;

  modport master (
    output stallE, BranchOpEb0, PCSrcResE, MispredictE, PredValidF, PredTakenF,
    input  GHRSpec, GHRArch, InFlight, InFlightFull
  );

  modport slave (
    input  stallE, BranchOpEb0, PCSrcResE, MispredictE, PredValidF, PredTakenF,
    output GHRSpec, GHRArch, InFlight, InFlightFull
  );

endinterface

// File: rtl/ghr_shift_reg.sv
// History register: newest bit enters at the LSB; parallel load wins over shift.
module ghr_shift_reg #(
  parameter int                HIST_W    = 2,
  parameter logic [HIST_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              shift_bit,
  input  logic              load_en,
  input  logic [HIST_W-1:0] load_val,
  output logic [HIST_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (load_en) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= {q[HIST_W-2:0], shift_bit};
    end
  end

endmodule

// File: rtl/ghr_spec.sv
// Global history register with speculative and architectural copies and a
// bounded count of unresolved predictions that back-pressures fetch.
module ghr_spec
  import ghr_pkg::*;
#(
  parameter int                HIST_W       = DEF_HIST_W,
  parameter logic [HIST_W-1:0] RESET_VAL    = HIST_W'(GHR_RESET_DEFAULT),
  parameter int                MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input logic        clk,
  input logic        reset,
  ghr_spec_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic              resolve;
  logic              flush;
  logic              accept;
  logic              full;
  logic [HIST_W-1:0] arch_q;
  logic [HIST_W-1:0] spec_q;
  logic [HIST_W-1:0] arch_next;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  assign resolve   = bus.BranchOpEb0 & ~bus.stallE;
  assign flush     = resolve & bus.MispredictE;
  assign full      = (cnt_q == CNT_W'(MAX_INFLIGHT));
  assign accept    = bus.PredValidF & ~full;
  assign arch_next = {arch_q[HIST_W-2:0], bus.PCSrcResE};

  ghr_shift_reg #(.HIST_W(HIST_W), .RESET_VAL(RESET_VAL)) u_arch (
    .clk       (clk),
    .rst_n     (reset),
    .shift_en  (resolve),
    .shift_bit (bus.PCSrcResE),
    .load_en   (1'b0),
    .load_val  ('0),
    .q         (arch_q)
  );

  // A flush reloads the speculative copy with the freshly resolved history,
  // discarding any same-cycle prediction from the wrong path.
  ghr_shift_reg #(.HIST_W(HIST_W), .RESET_VAL(RESET_VAL)) u_spec (
    .clk       (clk),
    .rst_n     (reset),
    .shift_en  (accept),
    .shift_bit (bus.PredTakenF),
    .load_en   (flush),
    .load_val  (arch_next),
    .q         (spec_q)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept && !resolve) begin
      cnt_d = cnt_q + 1'b1;
    end else if (resolve && !accept && (cnt_q != '0)) begin
      // Resolving an unpredicted branch leaves the count at zero.
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.GHRSpec      = spec_q;
  assign bus.GHRArch      = arch_q;
  assign bus.InFlight     = cnt_q;
  assign bus.InFlightFull = full;

endmodule

// File: tb/tb_ghr_spec.sv
// Directed bench for ghr_spec: a 4-bit instance for the main scenarios and a
// default 2-bit instance for reset values and the legacy history sequence.
module tb_ghr_spec;
  import ghr_pkg::*;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  ghr_spec_if #(.HIST_W(4), .MAX_INFLIGHT(4)) b4 ();
  ghr_spec_if #(.HIST_W(2), .MAX_INFLIGHT(4)) b2 ();

  ghr_spec #(.HIST_W(4), .RESET_VAL(4'b0001), .MAX_INFLIGHT(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4)
  );

  ghr_spec dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle();
    b4.stallE = 0; b4.BranchOpEb0 = 0; b4.PCSrcResE = 0;
    b4.MispredictE = 0; b4.PredValidF = 0; b4.PredTakenF = 0;
    b2.stallE = 0; b2.BranchOpEb0 = 0; b2.PCSrcResE = 0;
    b2.MispredictE = 0; b2.PredValidF = 0; b2.PredTakenF = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic pred4(input logic taken);
    b4.PredValidF = 1; b4.PredTakenF = taken;
    tick();
    idle();
  endtask

  task automatic res4(input logic outcome, input logic misp);
    b4.BranchOpEb0 = 1; b4.PCSrcResE = outcome; b4.MispredictE = misp;
    tick();
    idle();
  endtask

  task automatic cmp(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] es, input logic [3:0] ea,
                      input logic [2:0] ei, input logic ef);
    cmp({tag, ".spec"}, 16'(b4.GHRSpec), 16'(es));
    cmp({tag, ".arch"}, 16'(b4.GHRArch), 16'(ea));
    cmp({tag, ".inflight"}, 16'(b4.InFlight), 16'(ei));
    cmp({tag, ".full"}, 16'(b4.InFlightFull), 16'(ef));
  endtask

  task automatic chk2(input string tag, input logic [1:0] es, input logic [1:0] ea,
                      input logic [2:0] ei, input logic ef);
    cmp({tag, ".spec"}, 16'(b2.GHRSpec), 16'(es));
    cmp({tag, ".arch"}, 16'(b2.GHRArch), 16'(ea));
    cmp({tag, ".inflight"}, 16'(b2.InFlight), 16'(ei));
    cmp({tag, ".full"}, 16'(b2.InFlightFull), 16'(ef));
  endtask

  // Legacy 2-bit GHR written as a state table.
  function automatic ghr2_state_e legacy_next(input ghr2_state_e s, input logic b);
    case (s)
      UU:      return b ? UT : UU;
      UT:      return b ? TT : TU;
      TU:      return b ? UT : UU;
      default: return b ? TT : TU;
    endcase
  endfunction

  // scoreboard for the legacy sequence
  logic [1:0]  exp_q[$];
  ghr2_state_e model;

  initial begin
    idle();
    reset = 1'b1;
    #2;
    do_reset();
    chk4("rst4", 4'b0001, 4'b0001, 3'd0, 1'b0);
    chk2("rst2", 2'b01, 2'b01, 3'd0, 1'b0);

    // speculate T,T,N then resolve the same outcomes
    pred4(1); pred4(1); pred4(0);
    chk4("spec_ttn", 4'b1110, 4'b0001, 3'd3, 1'b0);
    res4(1, 0); res4(1, 0); res4(0, 0);
    chk4("resolve_ttn", 4'b1110, 4'b1110, 3'd0, 1'b0);

    // mispredict without a branch in E is ignored
    b4.MispredictE = 1; b4.PCSrcResE = 1;
    tick(); idle();
    chk4("misp_no_branch", 4'b1110, 4'b1110, 3'd0, 1'b0);

    // mispredict recovery with a same-cycle prediction discarded
    do_reset();
    pred4(1); pred4(1);
    chk4("spec_tt", 4'b0111, 4'b0001, 3'd2, 1'b0);
    b4.BranchOpEb0 = 1; b4.PCSrcResE = 0; b4.MispredictE = 1;
    b4.PredValidF = 1; b4.PredTakenF = 1;
    tick(); idle();
    chk4("flush", 4'b0010, 4'b0010, 3'd0, 1'b0);

    // back-pressure
    do_reset();
    pred4(1); pred4(1); pred4(1);
    chk4("three_inflight", 4'b1111, 4'b0001, 3'd3, 1'b0);
    pred4(1);
    chk4("full", 4'b1111, 4'b0001, 3'd4, 1'b1);
    pred4(0);
    chk4("drop_when_full", 4'b1111, 4'b0001, 3'd4, 1'b1);
    res4(1, 0);
    chk4("release", 4'b1111, 4'b0011, 3'd3, 1'b0);

    // stalled E: resolve and mispredict frozen, prediction still accepted
    b4.stallE = 1; b4.BranchOpEb0 = 1; b4.PCSrcResE = 1; b4.MispredictE = 1;
    b4.PredValidF = 1; b4.PredTakenF = 0;
    tick(); idle();
    chk4("stall", 4'b1110, 4'b0011, 3'd4, 1'b1);
    res4(1, 0);
    chk4("res_after_stall", 4'b1110, 4'b0111, 3'd3, 1'b0);

    // accept and correct resolve together
    b4.BranchOpEb0 = 1; b4.PCSrcResE = 1; b4.PredValidF = 1; b4.PredTakenF = 1;
    tick(); idle();
    chk4("accept_and_resolve", 4'b1101, 4'b1111, 3'd3, 1'b0);

    // asynchronous reset between clock edges
    #2;
    reset = 1'b0;
    #1;
    chk4("async_rst4", 4'b0001, 4'b0001, 3'd0, 1'b0);
    chk2("async_rst2", 2'b01, 2'b01, 3'd0, 1'b0);
    #1;
    reset = 1'b1;
    tick();

    // unpredicted resolves keep the counter at zero
    res4(1, 0);
    chk4("unpred_1", 4'b0001, 4'b0011, 3'd0, 1'b0);
    res4(0, 0);
    chk4("unpred_2", 4'b0001, 4'b0110, 3'd0, 1'b0);

    // legacy 2-bit regression: outcomes toggle every 4 resolves
    model = UT;
    for (int i = 0; i < 32; i++) begin
      logic b;
      b = ((i / 4) % 2) == 1;
      model = legacy_next(model, b);
      exp_q.push_back(model);
      b2.BranchOpEb0 = 1; b2.PCSrcResE = b;
      tick(); idle();
      cmp($sformatf("legacy_%0d", i), 16'(b2.GHRArch), 16'(exp_q.pop_front()));
    end
    chk2("legacy_end", 2'b01, 2'b11, 3'd0, 1'b0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ghr_spec.md
# ghr_spec

Parametrised global history register (GHR) with speculative and architectural copies, the successor to the fixed 2-bit GHR that feeds the branch predictor's local-predictor select.
- The speculative copy shifts in predicted outcomes at prediction time (F stage).
- The architectural copy shifts in resolved outcomes in the E stage.
- On a misprediction, the speculative copy is rebuilt from the architectural one.
- A bounded in-flight counter tracks predictions not yet resolved and raises back-pressure to fetch when full.

## Interface
Parameters:
- HIST_W, 2, history length in bits; legal range 2..16.
- RESET_VAL, 2'b01, reset value of both history copies; its width is HIST_W.
- MAX_INFLIGHT, 4, maximum number of unresolved predictions; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stallE  in  1  E stage stalled; blocks resolution.
- BranchOpEb0  in  1  the instruction in E is a conditional branch.
- PCSrcResE  in  1  resolved branch outcome (1 = taken).
- MispredictE  in  1  the resolved outcome differs from the prediction.
- PredValidF  in  1  a conditional-branch prediction was made in F this cycle.
- PredTakenF  in  1  predicted direction.
- GHRSpec  out  HIST_W  speculative history, indexed by the predictor.
- GHRArch  out  HIST_W  architectural (resolved) history.
- InFlight  out  $clog2(MAX_INFLIGHT+1)  count of unresolved predictions.
- InFlightFull  out  1  asserted when InFlight == MAX_INFLIGHT; fetch must stall.

## Operation
Events:
- Resolve event: R = BranchOpEb0 & ~stallE.
- Accept event: A = PredValidF & ~InFlightFull.
- Shift rule: shift(h, b) = {h[HIST_W-2:0], b]}. The newest outcome enters at the LSB and the oldest bit is discarded.
- MispredictE is ignored when R = 0.

Architectural copy:
- On R: GHRArch <= shift(GHRArch, PCSrcResE).
- Otherwise it holds.

Speculative copy, in priority order:
1. R & MispredictE: GHRSpec <= shift(GHRArch, PCSrcResE), i.e. the new architectural value. Any prediction in the same cycle is discarded, because it belongs to the flushed path.
2. A: GHRSpec <= shift(GHRSpec, PredTakenF).
3. Otherwise hold.

Counter:
- R & MispredictE: InFlight <= 0.
- A & R (no mispredict): InFlight unchanged.
- A only: InFlight + 1.
- R only (no mispredict): InFlight - 1, saturating at 0. A resolve with InFlight = 0 is legal: the branch was not predicted, so only GHRArch updates.
- PredValidF while InFlightFull: prediction dropped; GHRSpec and InFlight unchanged.

Invariant: with no mispredict since the last reset or flush, GHRSpec equals GHRArch shifted by the InFlight outstanding predicted bits.

## Timing
- All outputs are registered. An event at edge n is visible after edge n.
- Latency is one cycle from the qualifying inputs to the updated outputs.
- InFlightFull is combinational from the InFlight register only; it has no input-to-output path.
- Reset values: GHRSpec = GHRArch = RESET_VAL, InFlight = 0, InFlightFull = 0.
- Reset takes effect immediately and asynchronously, including mid-operation. Deassertion is synchronised externally.
- When stallE = 1, GHRArch and the resolve half of the counter update freeze. Predictions in F are still accepted.

## Structure
- Package ghr_pkg holds:
  - GHR_RESET_DEFAULT = 2'b01
  - the named 2-bit state constants UU = 00, UT = 01, TU = 10, TT = 11, kept for HIST_W = 2 users
  - the default parameter values
- Sub-module ghr_shift_reg: parametrised HIST_W register with async active-low reset to RESET_VAL, shift-enable, and parallel load. It is instantiated twice (spec and arch), with the load port used only by the spec copy.
- Counter and priority logic live in the top level.

## Test plan
- Reset: hold reset low, pulse clk, release → GHRSpec = GHRArch = 01, InFlight = 0, InFlightFull = 0. Assert reset mid-run → all outputs return to these values without waiting for a clock edge.
- Speculate and resolve (HIST_W = 4, RESET_VAL = 0001):
  - Predict T, T, N → GHRSpec = 1110, InFlight = 3.
  - Resolve T, T, N with MispredictE = 0 → GHRArch = 1110, InFlight = 0.
- Mispredict recovery (same configuration):
  - Predict T, T → GHRSpec = 0111.
  - Resolve first as N with MispredictE = 1, and PredValidF = 1 in the same cycle → GHRSpec = GHRArch = 0010, InFlight = 0.
- Full back-pressure (MAX_INFLIGHT = 4):
  - Issue 5 predictions → InFlightFull = 1 after the 4th; the 5th is dropped and GHRSpec is unchanged.
  - One correct resolve → InFlightFull = 0.
- Stall and simultaneous events:
  - stallE = 1 with BranchOpEb0 = 1 → GHRArch holds.
  - Accept and non-mispredict resolve in the same cycle → InFlight unchanged, both copies shift.
- Unpredicted resolve: resolve with InFlight = 0 → GHRArch shifts, InFlight stays 0.
- Regression against the 2-bit model: drive 32 resolves with outcomes toggling every 4 → GHRArch follows the UU/UT/TU/TT sequence of the legacy 2-bit GHR.
